// File: rtl/qed_pkg.sv
// Shared encodings for the SQED instruction-legality filter: RV32 opcode/funct
// fields of the supported subset and the static instruction classes.
package qed_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_NOP   = 7'b1111111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_W       = 3'b010;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    typedef enum logic [2:0] {
        CLS_ILLEGAL = 3'd0,
        CLS_R       = 3'd1,
        CLS_I       = 3'd2,
        CLS_LW      = 3'd3,
        CLS_SW      = 3'd4,
        CLS_NOP     = 3'd5
    } inst_class_e;

endpackage

// File: rtl/qed_inst_decode.sv
// Stateless classifier: maps a 32-bit instruction to its class, or CLS_ILLEGAL
// when it lies outside the enabled subset or touches a duplicate-half register.
module qed_inst_decode
    import qed_pkg::*;
#(
    parameter int ORIG_REGS = 16,
    parameter bit EN_MUL    = 1'b1,
    parameter bit EN_MEM    = 1'b1
) (
    input  logic [31:0]  instruction,
    output inst_class_e  inst_class
);

    localparam logic [5:0] REG_LIM = 6'(ORIG_REGS);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       r_op_ok;
    logic       i_op_ok;
    logic       mem_form_ok;

    function automatic logic reg_ok(input logic [4:0] r);
        return {1'b0, r} < REG_LIM;
    endfunction

    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign funct7 = instruction[31:25];

    // LW/SW only with base x0 and a small non-negative offset
    assign mem_form_ok = EN_MEM && (funct3 == F3_W) && (rs1 == 5'd0)
                         && (instruction[31:30] == 2'b00);

    always_comb begin
        r_op_ok = 1'b0;
        case (funct7)
            F7_BASE: r_op_ok = 1'b1;
            F7_ALT:  r_op_ok = (funct3 == F3_ADD_SUB) || (funct3 == F3_SRL_SRA);
            F7_MUL:  r_op_ok = EN_MUL && !funct3[2];
            default: r_op_ok = 1'b0;
        endcase

        i_op_ok = 1'b1;
        case (funct3)
            F3_SLL:     i_op_ok = (funct7 == F7_BASE);
            F3_SRL_SRA: i_op_ok = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            default:    i_op_ok = 1'b1;
        endcase

        inst_class = CLS_ILLEGAL;
        case (opcode)
            OP_R:
                if (r_op_ok && reg_ok(rd) && reg_ok(rs1) && reg_ok(rs2))
                    inst_class = CLS_R;
            OP_IMM:
                if (i_op_ok && reg_ok(rd) && reg_ok(rs1))
                    inst_class = CLS_I;
            OP_LOAD:
                if (mem_form_ok && reg_ok(rd))
                    inst_class = CLS_LW;
            OP_STORE:
                if (mem_form_ok && reg_ok(rs2))
                    inst_class = CLS_SW;
            OP_NOP:
                inst_class = CLS_NOP;
            default:
                inst_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/qed_inst_constraint_seq.sv
// Stateful legality filter for the SQED harness: static decode plus an
// instruction budget, a memory-op cooldown and a sticky violation flag.
module qed_inst_constraint_seq
    import qed_pkg::*;
#(
    parameter int ORIG_REGS = 16,
    parameter bit EN_MUL    = 1'b1,
    parameter bit EN_MEM    = 1'b1,
    parameter int MAX_INSTS = 16,
    parameter int MEM_GAP   = 1,
    parameter int CNT_W     = $clog2(MAX_INSTS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instruction,
    input  logic             inst_valid,
    output logic             allowed,
    output logic [2:0]       inst_class,
    output logic [CNT_W-1:0] inst_count,
    output logic             budget_done,
    output logic             violation
);

    localparam int                COOL_W    = (MEM_GAP > 0) ? $clog2(MEM_GAP + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_INSTS);
    localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(MEM_GAP);

    inst_class_e       cls;
    logic [COOL_W-1:0] mem_cool;
    logic              is_mem;
    logic              accept;

    qed_inst_decode #(
        .ORIG_REGS (ORIG_REGS),
        .EN_MUL    (EN_MUL),
        .EN_MEM    (EN_MEM)
    ) u_decode (
        .instruction (instruction),
        .inst_class  (cls)
    );

    assign inst_class  = cls;
    assign is_mem      = (cls == CLS_LW) || (cls == CLS_SW);
    assign budget_done = (inst_count == CNT_MAX);
    // NOPs stay legal after the budget is spent so the run can drain
    assign allowed     = (cls != CLS_ILLEGAL)
                         && !(budget_done && (cls != CLS_NOP))
                         && !((mem_cool != '0) && is_mem);
    assign accept      = inst_valid && allowed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_count <= '0;
            mem_cool   <= '0;
            violation  <= 1'b0;
        end else begin
            if (accept && (cls != CLS_NOP) && !budget_done)
                inst_count <= inst_count + CNT_W'(1);
            // cooldown is a free-running timer, not gated by inst_valid
            if (accept && is_mem)
                mem_cool <= COOL_LOAD;
            else if (mem_cool != '0)
                mem_cool <= mem_cool - COOL_W'(1);
            if (inst_valid && !allowed)
                violation <= 1'b1;
        end
    end

`ifdef FORMAL
    always @(posedge clk) begin
        assume property (!inst_valid || allowed);
    end
`endif

endmodule
